dibit_frame_ctrl: RTL and testbench
===================================

DIBIT_FRAME_CTRL -- requirements
Module: dibit_frame_ctrl

Interface
REQ-001 Parameter SYNC_LEN, default 8: sync word length in bits, 2..16.
REQ-002 Parameter SYNC_WORD, default 8'hE4: sync pattern, MSB received first, nonzero.
REQ-003 Parameter PAYLOAD_BITS, default 16: payload bits per frame, even, 2..256.
REQ-004 Parameter LOCK_FRAMES, default 2: consecutive sync matches needed to declare lock, >=1.
REQ-005 Parameter MISS_LIMIT, default 3: consecutive sync misses while locked that force re-hunt, >=1.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high; one clock, async active-high reset, fixed.
REQ-008 input_data  in  1  serial bit, one bit per clk.
REQ-009 sym_data  out  2  dibit, {first bit, second bit}.
REQ-010 sym_valid  out  1  one-cycle strobe, sym_data valid.
REQ-011 frame_start  out  1  high with first sym_valid of a frame.
REQ-012 frame_end  out  1  high with last sym_valid of a frame.
REQ-013 locked  out  1  frame lock indicator.
REQ-014 state  out  2  FSM state: 0 HUNT, 1 PAYLOAD, 2 SYNC.
REQ-015 err_frames  out  8  saturating count of missed sync words.

Function
REQ-016 A SYNC_LEN-bit shift register SHALL shift input_data every cycle in all states, newest bit at LSB.
REQ-017 HUNT: when {sr[SYNC_LEN-2:0], input_data} == SYNC_WORD, next state PAYLOAD, bit counter 0, match counter 1.
REQ-018 PAYLOAD: bit counter counts 0..PAYLOAD_BITS-1; even-index bit latched as high bit, odd-index bit completes dibit.
REQ-019 sym_valid SHALL be registered: high the cycle after the odd-index bit is sampled, exactly PAYLOAD_BITS/2 strobes per frame.
REQ-020 frame_start on strobe 0, frame_end on strobe PAYLOAD_BITS/2-1; both high together only when PAYLOAD_BITS==2.
REQ-021 After bit PAYLOAD_BITS-1, next state SYNC, bit counter 0.
REQ-022 SYNC: count SYNC_LEN bits; on last bit compare {sr[SYNC_LEN-2:0], input_data} with SYNC_WORD.
REQ-023 SYNC match: miss counter cleared, match counter increments saturating at LOCK_FRAMES, next state PAYLOAD.
REQ-024 locked SHALL rise the cycle after match counter reaches LOCK_FRAMES (including the HUNT detection).
REQ-025 SYNC mismatch, unlocked: next state HUNT, match counter 0.
REQ-026 SYNC mismatch, locked: miss counter +1; if it reaches MISS_LIMIT -> HUNT, locked low, counters 0; else PAYLOAD (flywheel).
REQ-027 Every SYNC mismatch SHALL increment err_frames, saturating at 255.
REQ-028 sym_data/sym_valid SHALL be produced in PAYLOAD regardless of locked.
REQ-029 Sync pattern occurring inside payload SHALL be ignored; detection only in HUNT.
REQ-030 Outside PAYLOAD, sym_valid, frame_start, frame_end SHALL be 0, except the final strobe registered from the last payload bit.

Reset
REQ-031 reset high SHALL immediately clear: state HUNT, shift register, all counters, sym_data 0, sym_valid 0, frame_start 0, frame_end 0, locked 0, err_frames 0.
REQ-032 reset mid-frame SHALL discard the partial dibit; no strobe after release until a new sync is found.
REQ-033 First bit sampled is the one at the first rising edge after reset falls.

Structure
REQ-034 State encodings and default parameter values SHALL live in shared package dibit_pkg.
REQ-035 The shift register and comparator SHALL be one sub-module sync_detect (in: clk, reset, input_data; out: match).
REQ-036 Counter widths SHALL derive from parameters via $clog2.

Verification
REQ-037 Reset, then E4 followed by payload 16'hA5C3 -> 8 strobes, sym_data 2,2,1,1,3,0,0,3; frame_start on first, frame_end on last; locked 0.
REQ-038 Two frames with correct sync -> locked rises the cycle after 2nd sync compare; state 1 then.
REQ-039 Locked, then 3 consecutive corrupted syncs (E5) -> frames 1-2 still emit 8 strobes each, err_frames 1,2,3, after 3rd locked 0, state 0.
REQ-040 Unlocked after one detection, corrupted sync -> immediate HUNT, err_frames 1, no further strobes.
REQ-041 Payload containing E4 while in PAYLOAD -> no re-alignment; strobe count per frame stays 8.
REQ-042 reset asserted after 5 payload bits -> all outputs 0 same cycle; after release, 16 zero bits -> no strobes, state 0.

Source files
------------

// File: rtl/dibit_pkg.sv
// Shared definitions for the dibit frame controller: FSM state encoding and
// default parameter values.
package dibit_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_SYNC    = 2'd2
    } state_t;

    localparam int unsigned DEF_SYNC_LEN     = 8;
    localparam logic [7:0]  DEF_SYNC_WORD    = 8'hE4;
    localparam int unsigned DEF_PAYLOAD_BITS = 16;
    localparam int unsigned DEF_LOCK_FRAMES  = 2;
    localparam int unsigned DEF_MISS_LIMIT   = 3;

endpackage

// File: rtl/dibit_frame_ctrl_sync_detect.sv
// sync_detect: serial shift register plus sync-word comparator.
// Ports:
//   clk, reset  - clock, async active-high reset
//   input_data  - serial bit, one per clk
//   match       - high when the last SYNC_LEN bits (including the live input
//                 bit) equal SYNC_WORD
module sync_detect #(
    parameter int unsigned            SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0]    SYNC_WORD = SYNC_LEN'(8'hE4)
) (
    input  logic clk,
    input  logic reset,
    input  logic input_data,
    output logic match
);

    localparam int unsigned SR_W = SYNC_LEN - 1;

    // Only SYNC_LEN-1 history bits are kept; the live input bit completes the
    // SYNC_LEN-bit window, so the oldest shifted bit is never needed.
    logic [SR_W-1:0] sr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= SR_W'({sr_q, input_data});
        end
    end

    assign match = ({sr_q, input_data} == SYNC_WORD);

endmodule

// File: rtl/dibit_frame_ctrl.sv
// dibit_frame_ctrl: serial frame synchroniser and dibit packer.
// Hunts for SYNC_WORD, then packs PAYLOAD_BITS payload bits into dibits,
// checks the sync word between frames and flywheels through misses while
// locked.
// Ports:
//   clk, reset   - clock, async active-high reset
//   input_data   - serial bit, one per clk
//   sym_data     - dibit {first bit, second bit}
//   sym_valid    - one-cycle strobe for sym_data
//   frame_start  - with first strobe of a frame
//   frame_end    - with last strobe of a frame
//   locked       - frame lock indicator
//   state        - FSM state (0 HUNT, 1 PAYLOAD, 2 SYNC)
//   err_frames   - saturating missed-sync count
module dibit_frame_ctrl
    import dibit_pkg::*;
#(
    parameter int unsigned         SYNC_LEN     = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD    = SYNC_LEN'(DEF_SYNC_WORD),
    parameter int unsigned         PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int unsigned         LOCK_FRAMES  = DEF_LOCK_FRAMES,
    parameter int unsigned         MISS_LIMIT   = DEF_MISS_LIMIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       input_data,
    output logic [1:0] sym_data,
    output logic       sym_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       locked,
    output logic [1:0] state,
    output logic [7:0] err_frames
);

    localparam int unsigned CNT_MAX = (PAYLOAD_BITS > SYNC_LEN) ? PAYLOAD_BITS : SYNC_LEN;
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam int unsigned MW      = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned XW      = $clog2(MISS_LIMIT + 1);

    logic match;

    state_t         state_q, state_n;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_n;
    logic [MW-1:0]  match_cnt_q, match_cnt_n;
    logic [XW-1:0]  miss_cnt_q, miss_cnt_n;
    logic           hi_bit_q, hi_bit_n;
    logic [1:0]     sym_data_q, sym_data_n;
    logic           sym_valid_q, sym_valid_n;
    logic           frame_start_q, frame_start_n;
    logic           frame_end_q, frame_end_n;
    logic           locked_q, locked_n;
    logic [7:0]     err_q, err_n;

    sync_detect #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_detect (
        .clk        (clk),
        .reset      (reset),
        .input_data (input_data),
        .match      (match)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            bit_cnt_q     <= '0;
            match_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            hi_bit_q      <= 1'b0;
            sym_data_q    <= 2'd0;
            sym_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 8'd0;
        end else begin
            state_q       <= state_n;
            bit_cnt_q     <= bit_cnt_n;
            match_cnt_q   <= match_cnt_n;
            miss_cnt_q    <= miss_cnt_n;
            hi_bit_q      <= hi_bit_n;
            sym_data_q    <= sym_data_n;
            sym_valid_q   <= sym_valid_n;
            frame_start_q <= frame_start_n;
            frame_end_q   <= frame_end_n;
            locked_q      <= locked_n;
            err_q         <= err_n;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_n       = state_q;
        bit_cnt_n     = bit_cnt_q;
        match_cnt_n   = match_cnt_q;
        miss_cnt_n    = miss_cnt_q;
        hi_bit_n      = hi_bit_q;
        sym_data_n    = sym_data_q;
        sym_valid_n   = 1'b0;
        frame_start_n = 1'b0;
        frame_end_n   = 1'b0;
        locked_n      = locked_q;
        err_n         = err_q;

        case (state_q)
            ST_HUNT: begin
                if (match) begin
                    state_n     = ST_PAYLOAD;
                    bit_cnt_n   = '0;
                    match_cnt_n = MW'(1);
                end
            end

            ST_PAYLOAD: begin
                if (!bit_cnt_q[0]) begin
                    hi_bit_n = input_data;
                end else begin
                    sym_data_n    = {hi_bit_q, input_data};
                    sym_valid_n   = 1'b1;
                    frame_start_n = (bit_cnt_q == CW'(1));
                    frame_end_n   = (bit_cnt_q == CW'(PAYLOAD_BITS - 1));
                end
                if (bit_cnt_q == CW'(PAYLOAD_BITS - 1)) begin
                    state_n   = ST_SYNC;
                    bit_cnt_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt_q + CW'(1);
                end
            end

            ST_SYNC: begin
                if (bit_cnt_q == CW'(SYNC_LEN - 1)) begin
                    bit_cnt_n = '0;
                    if (err_q != 8'hFF && !match) begin
                        err_n = err_q + 8'd1;
                    end
                    if (match) begin
                        state_n    = ST_PAYLOAD;
                        miss_cnt_n = '0;
                        if (match_cnt_q != MW'(LOCK_FRAMES)) begin
                            match_cnt_n = match_cnt_q + MW'(1);
                        end
                    end else if (!locked_q) begin
                        state_n     = ST_HUNT;
                        match_cnt_n = '0;
                    end else if (miss_cnt_q + XW'(1) == XW'(MISS_LIMIT)) begin
                        state_n     = ST_HUNT;
                        locked_n    = 1'b0;
                        match_cnt_n = '0;
                        miss_cnt_n  = '0;
                    end else begin
                        // Flywheel: trust the frame timing through the miss
                        state_n    = ST_PAYLOAD;
                        miss_cnt_n = miss_cnt_q + XW'(1);
                    end
                end else begin
                    bit_cnt_n = bit_cnt_q + CW'(1);
                end
            end

            default: begin
                state_n = ST_HUNT;
            end
        endcase

        // Lock declared once the match counter reaches its target
        if (match_cnt_n == MW'(LOCK_FRAMES)) begin
            locked_n = 1'b1;
        end
    end

    assign sym_data    = sym_data_q;
    assign sym_valid   = sym_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign locked      = locked_q;
    assign state       = 2'(state_q);
    assign err_frames  = err_q;

endmodule

// File: tb/tb_dibit_frame_ctrl.sv
// Directed self-checking bench for dibit_frame_ctrl (default parameters).
`timescale 1ns/1ps
module tb_dibit_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       input_data;
    logic [1:0] sym_data;
    logic       sym_valid;
    logic       frame_start;
    logic       frame_end;
    logic       locked;
    logic [1:0] state;
    logic [7:0] err_frames;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-frame capture of strobes
    int          strobe_cnt;
    logic [15:0] sym_pack;
    logic [7:0]  fs_mask;
    logic [7:0]  fe_mask;

    dibit_frame_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .input_data  (input_data),
        .sym_data    (sym_data),
        .sym_valid   (sym_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .locked      (locked),
        .state       (state),
        .err_frames  (err_frames)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_capture();
        strobe_cnt = 0;
        sym_pack   = 16'h0;
        fs_mask    = 8'h0;
        fe_mask    = 8'h0;
    endtask

    // Drive one bit, let one edge sample it, then record any strobe
    task automatic send_bit(input logic b);
        input_data = b;
        @(posedge clk);
        #1;
        if (sym_valid) begin
            if (strobe_cnt < 8) begin
                if (frame_start) fs_mask[strobe_cnt] = 1'b1;
                if (frame_end)   fe_mask[strobe_cnt] = 1'b1;
            end
            sym_pack = {sym_pack[13:0], sym_data};
            strobe_cnt++;
        end
    endtask

    task automatic send_word(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    task automatic check_frame(input string pfx, input logic [15:0] exp_pack);
        check({pfx, "_strobes"}, 32'(strobe_cnt), 32'd8);
        check({pfx, "_data"}, 32'(sym_pack), 32'(exp_pack));
        check({pfx, "_fstart"}, 32'(fs_mask), 32'h01);
        check({pfx, "_fend"}, 32'(fe_mask), 32'h80);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        input_data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(sym_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err", 32'(err_frames), 32'd0);

        // First frame after a HUNT detection: dibits 2,2,1,1,3,0,0,3
        send_word(16'h00E4, 8);
        check("hunt_det_state", 32'(state), 32'd1);
        clear_capture();
        send_word(16'hA5C3, 16);
        check_frame("f1", 16'hA5C3);
        check("f1_locked", 32'(locked), 32'd0);
        check("f1_state_sync", 32'(state), 32'd2);

        // Second correct sync: lock after the compare edge
        send_word(16'h0072, 7);
        check("sync2_prelock", 32'(locked), 32'd0);
        send_bit(1'b0);
        check("sync2_locked", 32'(locked), 32'd1);
        check("sync2_state", 32'(state), 32'd1);
        clear_capture();
        send_word(16'hA5C3, 16);
        check_frame("f2", 16'hA5C3);

        // Three corrupted syncs while locked: two flywheel frames, then re-hunt
        send_word(16'h00E5, 8);
        check("miss1_err", 32'(err_frames), 32'd1);
        check("miss1_state", 32'(state), 32'd1);
        check("miss1_locked", 32'(locked), 32'd1);
        clear_capture();
        send_word(16'h1234, 16);
        check_frame("fly1", 16'h1234);
        send_word(16'h00E5, 8);
        check("miss2_err", 32'(err_frames), 32'd2);
        check("miss2_state", 32'(state), 32'd1);
        clear_capture();
        send_word(16'hFF00, 16);
        check_frame("fly2", 16'hFF00);
        send_word(16'h00E5, 8);
        check("miss3_err", 32'(err_frames), 32'd3);
        check("miss3_locked", 32'(locked), 32'd0);
        check("miss3_state", 32'(state), 32'd0);

        // Unlocked miss: straight back to HUNT, no further strobes
        do_reset();
        check("rst2_err", 32'(err_frames), 32'd0);
        send_word(16'h00E4, 8);
        clear_capture();
        send_word(16'h5A3C, 16);
        check_frame("u1", 16'h5A3C);
        send_word(16'h00E5, 8);
        check("umiss_state", 32'(state), 32'd0);
        check("umiss_err", 32'(err_frames), 32'd1);
        clear_capture();
        send_word(16'h0000, 16);
        check("umiss_nostrobe", 32'(strobe_cnt), 32'd0);
        check("umiss_hunt", 32'(state), 32'd0);

        // Sync pattern inside payload must not re-align
        do_reset();
        send_word(16'h00E4, 8);
        clear_capture();
        send_word(16'h00E4, 16);
        check_frame("emb1", 16'h00E4);
        check("emb_state_sync", 32'(state), 32'd2);
        send_word(16'h00E4, 8);
        check("emb_sync_ok", 32'(state), 32'd1);
        check("emb_err", 32'(err_frames), 32'd0);
        clear_capture();
        send_word(16'hE4E4, 16);
        check_frame("emb2", 16'hE4E4);

        // Reset after 5 payload bits clears everything immediately
        do_reset();
        send_word(16'h00E4, 8);
        send_word(16'h001F, 5);
        check("pre_rst_data", 32'(sym_data), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_data", 32'(sym_data), 32'd0);
        check("mid_rst_valid", 32'(sym_valid), 32'd0);
        check("mid_rst_fs", 32'(frame_start), 32'd0);
        check("mid_rst_fe", 32'(frame_end), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_capture();
        send_word(16'h0000, 16);
        check("post_rst_nostrobe", 32'(strobe_cnt), 32'd0);
        check("post_rst_state", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
